// File: rtl/id_ex_sb_if.sv
// ID-to-EX issue bus: decode-side instruction fields, stage results and the registered
// ID/EX operands. The master is the decode side and the slave is the issue stage.
interface id_ex_sb_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned RAW    = 5,
  parameter int unsigned NSTAGE = 3
);
  logic                   i_flush;
  logic                   i_adv;
  logic                   i_id_vld;
  logic [RAW-1:0]         i_rs1_raddr;
  logic [RAW-1:0]         i_rs2_raddr;
  logic                   i_rs1_used;
  logic                   i_rs2_used;
  logic [RAW-1:0]         i_rd_waddr;
  logic                   i_rd_wen;
  logic                   i_is_load;
  logic [XLEN-1:0]        i_rs1_rdata;
  logic [XLEN-1:0]        i_rs2_rdata;
  logic [NSTAGE*XLEN-1:0] i_stg_res;
  logic                   o_stall;
  logic                   o_vld;
  logic [RAW-1:0]         o_rd_waddr;
  logic                   o_rd_wen;
  logic [XLEN-1:0]        o_op1;
  logic [XLEN-1:0]        o_op2;
  logic [3:0]             o_fwd1_sel;
  logic [3:0]             o_fwd2_sel;

  modport master (
    output i_flush, i_adv, i_id_vld, i_rs1_raddr, i_rs2_raddr, i_rs1_used, i_rs2_used,
           i_rd_waddr, i_rd_wen, i_is_load, i_rs1_rdata, i_rs2_rdata, i_stg_res,
    input  o_stall, o_vld, o_rd_waddr, o_rd_wen, o_op1, o_op2, o_fwd1_sel, o_fwd2_sel
  );

  modport slave (
    input  i_flush, i_adv, i_id_vld, i_rs1_raddr, i_rs2_raddr, i_rs1_used, i_rs2_used,
           i_rd_waddr, i_rd_wen, i_is_load, i_rs1_rdata, i_rs2_rdata, i_stg_res,
    output o_stall, o_vld, o_rd_waddr, o_rd_wen, o_op1, o_op2, o_fwd1_sel, o_fwd2_sel
  );
endinterface

// File: rtl/id_ex_sb.sv
// ID/EX issue stage: scoreboard of in-flight destinations over NSTAGE stages, youngest-producer
// forwarding, load-use / latency hazard bubbles, flush and back-pressure.
module id_ex_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned RAW      = 5,
  parameter int unsigned NSTAGE   = 3,
  parameter int unsigned LOAD_RDY = 1
) (
  input logic       i_clk,
  input logic       i_rst,
  id_ex_sb_if.slave bus
);

  logic           e_vld_q  [NSTAGE];
  logic [RAW-1:0] e_rd_q   [NSTAGE];
  logic           e_wen_q  [NSTAGE];
  logic           e_load_q [NSTAGE];

  logic [XLEN-1:0] op1_q, op2_q;
  logic [3:0]      sel1_q, sel2_q;

  logic [RAW-1:0]  rs_a    [2];
  logic            rs_u    [2];
  logic [XLEN-1:0] rf_d    [2];
  logic            hit     [2];
  int unsigned     idx     [2];
  logic            not_rdy [2];
  logic [XLEN-1:0] op_d    [2];
  logic [3:0]      sel_d   [2];
  logic            hazard;
  logic            issue;

  assign rs_a[0] = bus.i_rs1_raddr;
  assign rs_a[1] = bus.i_rs2_raddr;
  assign rs_u[0] = bus.i_rs1_used;
  assign rs_u[1] = bus.i_rs2_used;
  assign rf_d[0] = bus.i_rs1_rdata;
  assign rf_d[1] = bus.i_rs2_rdata;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      hit[s]     = 1'b0;
      idx[s]     = 0;
      not_rdy[s] = 1'b0;
      op_d[s]    = rf_d[s];
      sel_d[s]   = 4'd0;
      // Scan oldest to youngest so the youngest match is the one left standing.
      for (int k = NSTAGE - 1; k >= 0; k--) begin
        if (e_vld_q[k] && e_wen_q[k] && (e_rd_q[k] == rs_a[s]) && (rs_a[s] != '0) && rs_u[s]) begin
          hit[s] = 1'b1;
          idx[s] = k;
        end
      end
      if (hit[s]) begin
        not_rdy[s] = e_load_q[idx[s]] && (idx[s] < LOAD_RDY);
        if (!not_rdy[s]) begin
          op_d[s]  = bus.i_stg_res[idx[s]*XLEN +: XLEN];
          sel_d[s] = 4'(idx[s] + 1);
        end
      end
      if (rs_a[s] == '0) begin
        op_d[s]  = '0;
        sel_d[s] = 4'd0;
      end
    end
  end

  assign hazard      = (not_rdy[0] || not_rdy[1]) && bus.i_id_vld && !bus.i_flush;
  assign issue       = bus.i_id_vld && !hazard && !bus.i_flush;
  assign bus.o_stall = hazard || !bus.i_adv;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NSTAGE; k++) begin
        e_vld_q[k]  <= 1'b0;
        e_rd_q[k]   <= '0;
        e_wen_q[k]  <= 1'b0;
        e_load_q[k] <= 1'b0;
      end
      op1_q  <= '0;
      op2_q  <= '0;
      sel1_q <= 4'd0;
      sel2_q <= 4'd0;
    end else if (bus.i_adv) begin
      for (int k = NSTAGE - 1; k >= 1; k--) begin
        e_vld_q[k]  <= e_vld_q[k-1];
        e_rd_q[k]   <= e_rd_q[k-1];
        e_wen_q[k]  <= e_wen_q[k-1];
        e_load_q[k] <= e_load_q[k-1];
      end
      if (issue) begin
        e_vld_q[0]  <= 1'b1;
        e_rd_q[0]   <= bus.i_rd_waddr;
        e_wen_q[0]  <= bus.i_rd_wen;
        e_load_q[0] <= bus.i_is_load;
        op1_q       <= op_d[0];
        op2_q       <= op_d[1];
        sel1_q      <= sel_d[0];
        sel2_q      <= sel_d[1];
      end else begin
        e_vld_q[0]  <= 1'b0;
        e_rd_q[0]   <= '0;
        e_wen_q[0]  <= 1'b0;
        e_load_q[0] <= 1'b0;
        op1_q       <= '0;
        op2_q       <= '0;
        sel1_q      <= 4'd0;
        sel2_q      <= 4'd0;
      end
    end
  end

  assign bus.o_vld      = e_vld_q[0];
  assign bus.o_rd_waddr = e_rd_q[0];
  assign bus.o_rd_wen   = e_wen_q[0];
  assign bus.o_op1      = op1_q;
  assign bus.o_op2      = op2_q;
  assign bus.o_fwd1_sel = sel1_q;
  assign bus.o_fwd2_sel = sel2_q;

endmodule

// File: tb/tb_id_ex_sb.sv
// Directed bench for id_ex_sb: expected ID/EX contents are queued as each instruction is
// driven and popped one clock later to compare against the registered outputs.
module tb_id_ex_sb;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic [31:0] res [3];

  id_ex_sb_if #(.XLEN(32), .RAW(5), .NSTAGE(3)) bus ();

  id_ex_sb #(.XLEN(32), .RAW(5), .NSTAGE(3), .LOAD_RDY(1)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  assign bus.i_stg_res = {res[2], res[1], res[0]};

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        vld;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic        ops;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic vld, input logic [4:0] rd, input logic wen,
                              input logic [31:0] op1, input logic [31:0] op2,
                              input logic [3:0] s1, input logic [3:0] s2, input logic ops);
    exp_t e;
    e.vld = vld; e.rd = rd; e.wen = wen; e.op1 = op1; e.op2 = op2;
    e.s1 = s1; e.s2 = s2; e.ops = ops;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic wen, input logic ld);
    bus.i_id_vld    = v;
    bus.i_rs1_raddr = r1;
    bus.i_rs2_raddr = r2;
    bus.i_rs1_used  = u1;
    bus.i_rs2_used  = u2;
    bus.i_rd_waddr  = rd;
    bus.i_rd_wen    = wen;
    bus.i_is_load   = ld;
  endtask

  // Called just after a posedge: checks stall, queues the expectation, clocks, compares.
  task automatic cyc(input string tag, input logic st, input exp_t e);
    exp_t g;
    #1;
    chk({tag, ".stall"}, {31'd0, bus.o_stall}, {31'd0, st});
    q.push_back(e);
    @(posedge i_clk);
    #1;
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s.queue: observed empty expected entry", tag);
    end else begin
      g = q.pop_front();
      chk({tag, ".vld"}, {31'd0, bus.o_vld}, {31'd0, g.vld});
      chk({tag, ".wen"}, {31'd0, bus.o_rd_wen}, {31'd0, g.wen});
      chk({tag, ".rd"}, {27'd0, bus.o_rd_waddr}, {27'd0, g.rd});
      if (g.ops) begin
        chk({tag, ".op1"}, bus.o_op1, g.op1);
        chk({tag, ".op2"}, bus.o_op2, g.op2);
        chk({tag, ".sel1"}, {28'd0, bus.o_fwd1_sel}, {28'd0, g.s1});
        chk({tag, ".sel2"}, {28'd0, bus.o_fwd2_sel}, {28'd0, g.s2});
      end
    end
  endtask

  initial begin
    res[0] = 32'h0; res[1] = 32'h0; res[2] = 32'h0;
    bus.i_flush = 1'b0;
    bus.i_adv   = 1'b1;
    bus.i_rs1_rdata = 32'h100;
    bus.i_rs2_rdata = 32'h200;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst.vld", {31'd0, bus.o_vld}, 32'd0);
    chk("rst.wen", {31'd0, bus.o_rd_wen}, 32'd0);
    chk("rst.op1", bus.o_op1, 32'd0);
    chk("rst.op2", bus.o_op2, 32'd0);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    // EX forwarding of x5
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    cyc("t1a", 1'b0, mk(1'b1, 5'd5, 1'b1, 32'h100, 32'h200, 4'd0, 4'd0, 1'b1));
    res[0] = 32'h11;
    drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    cyc("t1b", 1'b0, mk(1'b1, 5'd6, 1'b1, 32'h11, 32'h0, 4'd1, 4'd0, 1'b1));

    // x3 in EX and MEM: youngest wins; x6 from WB
    drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
    cyc("t3a", 1'b0, mk(1'b1, 5'd3, 1'b1, 32'h100, 32'h200, 4'd0, 4'd0, 1'b1));
    cyc("t3b", 1'b0, mk(1'b1, 5'd3, 1'b1, 32'h100, 32'h200, 4'd0, 4'd0, 1'b1));
    res[0] = 32'hA; res[1] = 32'hB; res[2] = 32'hC;
    drive(1'b1, 5'd3, 5'd6, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    cyc("t3c", 1'b0, mk(1'b1, 5'd9, 1'b1, 32'hA, 32'hC, 4'd1, 4'd3, 1'b1));

    // x0 never forwards
    drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    cyc("t4a", 1'b0, mk(1'b1, 5'd0, 1'b1, 32'h100, 32'h200, 4'd0, 4'd0, 1'b1));
    res[0] = 32'hFFFF;
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    cyc("t4b", 1'b0, mk(1'b1, 5'd0, 1'b0, 32'h0, 32'h0, 4'd0, 4'd0, 1'b1));

    // Load-use: one bubble then forward from MEM
    drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1);
    cyc("t2a", 1'b0, mk(1'b1, 5'd7, 1'b1, 32'h100, 32'h200, 4'd0, 4'd0, 1'b1));
    res[1] = 32'hDEAD;
    drive(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    cyc("t2b", 1'b1, mk(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 4'd0, 4'd0, 1'b0));
    cyc("t2c", 1'b0, mk(1'b1, 5'd8, 1'b1, 32'hDEAD, 32'hDEAD, 4'd2, 4'd2, 1'b1));

    // Freeze during a load-use hazard
    drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd10, 1'b1, 1'b1);
    cyc("t5a", 1'b0, mk(1'b1, 5'd10, 1'b1, 32'h100, 32'h200, 4'd0, 4'd0, 1'b1));
    res[1] = 32'hBEEF;
    drive(1'b1, 5'd10, 5'd2, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0);
    bus.i_adv = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc("t5frz", 1'b1, mk(1'b1, 5'd10, 1'b1, 32'h100, 32'h200, 4'd0, 4'd0, 1'b1));
    bus.i_adv = 1'b1;
    cyc("t5b", 1'b1, mk(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 4'd0, 4'd0, 1'b0));
    cyc("t5c", 1'b0, mk(1'b1, 5'd13, 1'b1, 32'hBEEF, 32'h200, 4'd2, 4'd0, 1'b1));

    // Flush beats hazard
    drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd11, 1'b1, 1'b1);
    cyc("t6a", 1'b0, mk(1'b1, 5'd11, 1'b1, 32'h100, 32'h200, 4'd0, 4'd0, 1'b1));
    drive(1'b1, 5'd11, 5'd2, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0);
    bus.i_flush = 1'b1;
    cyc("t6flush", 1'b0, mk(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 4'd0, 4'd0, 1'b0));
    bus.i_flush = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("t6idle", 1'b0, mk(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 4'd0, 4'd0, 1'b0));

    // Reset in the middle of a stall
    drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd12, 1'b1, 1'b1);
    cyc("t7a", 1'b0, mk(1'b1, 5'd12, 1'b1, 32'h100, 32'h200, 4'd0, 4'd0, 1'b1));
    drive(1'b1, 5'd12, 5'd2, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0);
    i_rst = 1'b1;
    cyc("t7rst", 1'b1, mk(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 4'd0, 4'd0, 1'b1));
    chk("t7rst.stall_after", {31'd0, bus.o_stall}, 32'd0);
    i_rst = 1'b0;
    cyc("t7b", 1'b0, mk(1'b1, 5'd14, 1'b1, 32'h100, 32'h200, 4'd0, 4'd0, 1'b1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
